// File: rtl/memory_io.sv
// -----------------------------------------------------------------------------
// memory_io_pkg
//
// Shared memory-port types used between the L1 caches, the port arbiter and
// main memory.
//   memory_io_req    : request (addr, write data, byte enables, tag, valid)
//   memory_io_rsp    : response (addr, read data, tag, valid, ready)
//   memory_io_no_req : idle request value (valid=0, dummy=1)
//   arb_state_t      : port arbiter FSM states
//   port_idx_t       : requester index, wide enough for the largest build
// -----------------------------------------------------------------------------
package memory_io_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 8;

    // The arbiter supports between 2 and MAX_PORTS requesters.
    localparam int MAX_PORTS  = 4;
    localparam int PORT_IDX_W = $clog2(MAX_PORTS);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        do_read;
        logic [3:0]        do_write;
        logic              valid;
        logic              dummy;
        logic [TAG_W-1:0]  user_tag;
    } memory_io_req;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              valid;
        logic              ready;
        logic [TAG_W-1:0]  user_tag;
    } memory_io_rsp;

    localparam memory_io_req memory_io_no_req = '{
        addr:     '0,
        data:     '0,
        do_read:  4'h0,
        do_write: 4'h0,
        valid:    1'b0,
        dummy:    1'b1,
        user_tag: '0
    };

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. The search starts one past last_grant and
// wraps modulo NUM_PORTS, so the most recently served port has lowest priority.
//   req        in  NUM_PORTS  pending request per port
//   last_grant in  port_idx_t port granted most recently
//   grant_idx  out port_idx_t selected port (0 when nothing is pending)
//   any        out 1          at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick
    import memory_io_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            last_grant,
    output port_idx_t            grant_idx,
    output logic                 any
);

    // Widening to MAX_PORTS lets the candidate index address the vector at its
    // natural width for every legal NUM_PORTS.
    logic [MAX_PORTS-1:0] req_ext;
    port_idx_t            cand;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block leaves it holding an old value
    // (which would infer a latch).
    always_comb begin
        req_ext                  = '0;
        req_ext[NUM_PORTS-1:0]   = req;
        grant_idx                = '0;
        any                      = 1'b0;
        cand                     = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = port_idx_t'((int'(last_grant) + i) % NUM_PORTS);
            if (!any && req_ext[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory_io port between NUM_PORTS cache requesters (port 0 = data
// cache, port 1 = instruction cache in the default build). Each port latches
// its one-cycle request pulse into a single-entry buffer; a round-robin winner
// is issued to memory with exactly one transaction outstanding, and the memory
// response is routed back to the owning port only.
//   clk          in  1              system clock
//   reset        in  1              synchronous, active-high reset
//   core_req[p]  in  memory_io_req  per-port request, valid is a 1-cycle pulse
//   core_rsp[p]  out memory_io_rsp  per-port response, ready = buffer empty
//   mem_req      out memory_io_req  request to memory
//   mem_rsp      in  memory_io_rsp  memory response (ready accepts, valid data)
//   protocol_err out 1              sticky: request arrived at a full buffer
// Legal NUM_PORTS range is 2..MAX_PORTS.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import memory_io_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  memory_io_req core_req [NUM_PORTS],
    output memory_io_rsp core_rsp [NUM_PORTS],
    output memory_io_req mem_req,
    input  memory_io_rsp mem_rsp,
    output logic         protocol_err
);

    arb_state_t   state_q, state_d;
    port_idx_t    owner_q, owner_d;
    port_idx_t    last_grant_q, last_grant_d;

    logic [NUM_PORTS-1:0] buf_valid;
    memory_io_req         buf_q [NUM_PORTS];
    memory_io_req         owner_buf;

    logic                 complete;
    logic [NUM_PORTS-1:0] done;
    logic [NUM_PORTS-1:0] accept;
    logic [NUM_PORTS-1:0] overflow;

    port_idx_t            pick_idx;
    logic                 pick_any;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .req        (buf_valid),
        .last_grant (last_grant_q),
        .grant_idx  (pick_idx),
        .any        (pick_any)
    );

    // Owner's buffered request, selected without indexing the array by a
    // wider-than-needed index.
    always_comb begin
        owner_buf = buf_q[0];
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (owner_q == port_idx_t'(p)) begin
                owner_buf = buf_q[p];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, memory request and completion strobe
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_req      = memory_io_no_req;
        complete     = 1'b0;

        case (state_q)
            IDLE: begin
                // A response arriving here is stale (pre-reset) and ignored.
                if (pick_any) begin
                    owner_d      = pick_idx;
                    last_grant_d = pick_idx;
                    state_d      = ISSUE;
                end
            end

            ISSUE: begin
                mem_req       = owner_buf;
                mem_req.valid = 1'b1;
                mem_req.dummy = 1'b0;
                if (mem_rsp.ready) begin
                    if (mem_rsp.valid) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end

            WAIT: begin
                if (mem_rsp.valid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= port_idx_t'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-port buffer control. A port completing this cycle may reload in
    // the same cycle; the load wins over the clear.
    // ------------------------------------------------------------------
    always_comb begin
        done     = '0;
        accept   = '0;
        overflow = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            done[p]     = complete && (owner_q == port_idx_t'(p));
            accept[p]   = core_req[p].valid && (!buf_valid[p] || done[p]);
            overflow[p] = core_req[p].valid && buf_valid[p] && !done[p];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid    <= '0;
            protocol_err <= 1'b0;
        end else begin
            buf_valid    <= accept | (buf_valid & ~done);
            protocol_err <= protocol_err | (|overflow);
        end
    end

    // NOTE: the buffer payload has no reset; it is only ever observed while
    // its buf_valid bit is set, and buf_valid is reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept[p]) begin
                buf_q[p] <= core_req[p];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing: zero-cycle pass-through to the owner only, all
    // payload fields zero on ports not being completed.
    // ------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            core_rsp[p]       = '0;
            core_rsp[p].ready = !buf_valid[p];
            if (done[p]) begin
                core_rsp[p].valid    = 1'b1;
                core_rsp[p].addr     = mem_rsp.addr;
                core_rsp[p].data     = mem_rsp.data;
                core_rsp[p].user_tag = mem_rsp.user_tag;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (NUM_PORTS = 2). Inputs change 1 ns after
// the rising edge; outputs are sampled 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import memory_io_pkg::*;

    localparam int NUM_PORTS = 2;

    logic         clk = 1'b0;
    logic         reset;
    memory_io_req core_req [NUM_PORTS];
    memory_io_rsp core_rsp [NUM_PORTS];
    memory_io_req mem_req;
    memory_io_rsp mem_rsp;
    logic         protocol_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_rsp     (core_rsp),
        .mem_req      (mem_req),
        .mem_rsp      (mem_rsp),
        .protocol_err (protocol_err)
    );

    // ---------------------------------------------------------------- helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < NUM_PORTS; p++) core_req[p] = memory_io_no_req;
        mem_rsp       = '0;
        mem_rsp.ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic memory_io_req make_req(input logic [31:0] addr,
                                              input logic [31:0] data,
                                              input logic        rd,
                                              input logic [7:0]  tag);
        memory_io_req r;
        r          = memory_io_no_req;
        r.addr     = addr;
        r.data     = data;
        r.do_read  = rd ? 4'hF : 4'h0;
        r.do_write = rd ? 4'h0 : 4'hF;
        r.user_tag = tag;
        r.valid    = 1'b1;
        r.dummy    = 1'b0;
        return r;
    endfunction

    // Waits (bounded) for mem_req.valid, records the payload, then answers
    // from WAIT in the following cycle. Returns in the completion cycle with
    // mem_rsp.valid still driven.
    task automatic mem_serve(input  logic [31:0]  rdata,
                             output memory_io_req seen,
                             output bit           timed_out);
        timed_out = 1'b1;
        seen      = memory_io_no_req;
        for (int c = 0; c < 20 && timed_out; c++) begin
            #1;
            if (mem_req.valid === 1'b1) begin
                seen      = mem_req;
                timed_out = 1'b0;
            end else begin
                @(posedge clk);
            end
        end
        if (!timed_out) begin
            step();
            mem_rsp.valid    = 1'b1;
            mem_rsp.addr     = seen.addr;
            mem_rsp.data     = rdata;
            mem_rsp.user_tag = seen.user_tag;
            #1;
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        memory_io_rsp rsp0;
        rsp0       = '0;
        rsp0.ready = 1'b1;
        reset      = 1'b1;
        clear_inputs();
        step();
        step();
        #1;
        n_checks++;
        if (mem_req !== memory_io_no_req) begin
            n_fail++;
            $display("FAIL reset_mem_req: got %h expected %h", mem_req, memory_io_no_req);
        end
        n_checks++;
        if (protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_protocol_err: got %b expected 0", protocol_err);
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            n_checks++;
            if (core_rsp[p] !== rsp0) begin
                n_fail++;
                $display("FAIL reset_core_rsp[%0d]: got %h expected %h", p, core_rsp[p], rsp0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        memory_io_req exp;
        exp = make_req(32'h1000, 32'h0, 1'b1, 8'h11);
        step();
        core_req[0] = exp;
        #1;
        n_checks++;
        if (mem_req.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c0_mem_valid: got %b expected 0", mem_req.valid);
        end
        step();
        core_req[0].valid = 1'b0;
        #1;
        n_checks++;
        if (core_rsp[0].ready !== 1'b0 || mem_req.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c1_buffered: ready=%b mem_valid=%b expected ready=0 mem_valid=0",
                     core_rsp[0].ready, mem_req.valid);
        end
        step();
        #1;
        n_checks++;
        if (mem_req !== exp) begin
            n_fail++;
            $display("FAIL single_c2_mem_req: got %h expected %h", mem_req, exp);
        end
        step();
        #1;
        n_checks++;
        if (mem_req.valid !== 1'b0 || core_rsp[1].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c3_wait: mem_valid=%b rsp1_valid=%b expected 0 0",
                     mem_req.valid, core_rsp[1].valid);
        end
        step();
        mem_rsp.valid    = 1'b1;
        mem_rsp.addr     = 32'h1000;
        mem_rsp.data     = 32'hDEADBEEF;
        mem_rsp.user_tag = 8'h11;
        #1;
        n_checks++;
        if (core_rsp[0].valid !== 1'b1 || core_rsp[0].data !== 32'hDEADBEEF ||
            core_rsp[0].user_tag !== 8'h11) begin
            n_fail++;
            $display("FAIL single_c4_rsp0: valid=%b data=%h tag=%h expected 1 deadbeef 11",
                     core_rsp[0].valid, core_rsp[0].data, core_rsp[0].user_tag);
        end
        n_checks++;
        if (core_rsp[1].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c4_rsp1: valid=%b expected 0", core_rsp[1].valid);
        end
        step();
        mem_rsp.valid = 1'b0;
        #1;
        n_checks++;
        if (core_rsp[0].ready !== 1'b1 || core_rsp[0].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c5_released: ready=%b valid=%b expected 1 0",
                     core_rsp[0].ready, core_rsp[0].valid);
        end
    endtask

    task automatic test_contention();
        memory_io_req seen;
        bit           to;
        logic [31:0]  exp_addr;
        logic [7:0]   exp_tag;
        logic [31:0]  rdata;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            step();
            for (int p = 0; p < NUM_PORTS; p++) begin
                core_req[p] = make_req(32'(32'h3000 + r * 16 + p * 4), 32'h0, 1'b1,
                                       8'(8'h30 + 2 * r + p));
            end
            step();
            for (int p = 0; p < NUM_PORTS; p++) core_req[p].valid = 1'b0;
            // Both ports pending each round: port 0 then port 1.
            for (int k = 0; k < 2; k++) begin
                exp_addr = 32'(32'h3000 + r * 16 + k * 4);
                exp_tag  = 8'(8'h30 + 2 * r + k);
                rdata    = 32'(32'hC0DE0000 + 2 * r + k);
                mem_serve(rdata, seen, to);
                n_checks++;
                if (to || seen.addr !== exp_addr || seen.user_tag !== exp_tag) begin
                    n_fail++;
                    $display("FAIL contention_grant r%0d k%0d: timeout=%0d addr=%h tag=%h expected addr=%h tag=%h",
                             r, k, to, seen.addr, seen.user_tag, exp_addr, exp_tag);
                end
                n_checks++;
                if (core_rsp[k].valid !== 1'b1 || core_rsp[k].user_tag !== exp_tag ||
                    core_rsp[k].data !== rdata || core_rsp[1-k].valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL contention_route r%0d k%0d: own_valid=%b tag=%h data=%h other_valid=%b expected 1 %h %h 0",
                             r, k, core_rsp[k].valid, core_rsp[k].user_tag, core_rsp[k].data,
                             core_rsp[1-k].valid, exp_tag, rdata);
                end
                step();
                mem_rsp.valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        memory_io_req seen;
        bit           to;
        logic [31:0]  rdata;
        step();
        core_req[1] = make_req(32'h2000, 32'h0, 1'b1, 8'h20);
        step();
        core_req[1].valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rdata = 32'(32'hF1110000 + i);
            mem_serve(rdata, seen, to);
            n_checks++;
            if (to || seen.addr !== 32'(32'h2000 + 4 * i)) begin
                n_fail++;
                $display("FAIL b2b_addr[%0d]: timeout=%0d got %h expected %h",
                         i, to, seen.addr, 32'(32'h2000 + 4 * i));
            end
            n_checks++;
            if (core_rsp[1].valid !== 1'b1 || core_rsp[1].data !== rdata) begin
                n_fail++;
                $display("FAIL b2b_rsp[%0d]: valid=%b data=%h expected 1 %h",
                         i, core_rsp[1].valid, core_rsp[1].data, rdata);
            end
            if (i < 7) begin
                core_req[1] = make_req(32'(32'h2000 + 4 * (i + 1)), 32'h0, 1'b1, 8'(8'h21 + i));
            end
            step();
            mem_rsp.valid     = 1'b0;
            core_req[1].valid = 1'b0;
        end
        #1;
        n_checks++;
        if (protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_protocol_err: got %b expected 0", protocol_err);
        end
        repeat (3) step();
        #1;
        n_checks++;
        if (core_rsp[1].ready !== 1'b1 || mem_req.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drained: ready=%b mem_valid=%b expected 1 0",
                     core_rsp[1].ready, mem_req.valid);
        end
    endtask

    task automatic test_backpressure();
        memory_io_req exp;
        exp = make_req(32'h4000, 32'hA5A50000, 1'b0, 8'h44);
        step();
        mem_rsp.ready = 1'b0;
        core_req[0]   = exp;
        step();
        core_req[0].valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (c == 3) mem_rsp.ready = 1'b1;
            #1;
            n_checks++;
            if (mem_req !== exp) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got %h expected %h", c, mem_req, exp);
            end
        end
        step();
        #1;
        n_checks++;
        if (mem_req.valid !== 1'b0 || core_rsp[0].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_wait: mem_valid=%b rsp_valid=%b expected 0 0",
                     mem_req.valid, core_rsp[0].valid);
        end
        step();
        mem_rsp.valid    = 1'b1;
        mem_rsp.addr     = 32'h4000;
        mem_rsp.data     = 32'h0;
        mem_rsp.user_tag = 8'h44;
        #1;
        n_checks++;
        if (core_rsp[0].valid !== 1'b1 || core_rsp[0].user_tag !== 8'h44) begin
            n_fail++;
            $display("FAIL backpressure_rsp: valid=%b tag=%h expected 1 44",
                     core_rsp[0].valid, core_rsp[0].user_tag);
        end
        step();
        mem_rsp.valid = 1'b0;
    endtask

    task automatic test_overflow();
        bit issued;
        step();
        core_req[0] = make_req(32'h5000, 32'h0, 1'b1, 8'h50);
        step();
        core_req[0] = make_req(32'h5100, 32'h0, 1'b1, 8'h51);
        #1;
        n_checks++;
        if (protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_before: got %b expected 0", protocol_err);
        end
        step();
        core_req[0] = make_req(32'h5200, 32'h0, 1'b1, 8'h52);
        #1;
        n_checks++;
        if (protocol_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flag: got %b expected 1", protocol_err);
        end
        n_checks++;
        if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h5000 || mem_req.user_tag !== 8'h50) begin
            n_fail++;
            $display("FAIL overflow_issue: valid=%b addr=%h tag=%h expected 1 5000 50",
                     mem_req.valid, mem_req.addr, mem_req.user_tag);
        end
        step();
        core_req[0].valid = 1'b0;
        step();
        mem_rsp.valid    = 1'b1;
        mem_rsp.addr     = 32'h5000;
        mem_rsp.data     = 32'h1234;
        mem_rsp.user_tag = 8'h50;
        #1;
        n_checks++;
        if (core_rsp[0].valid !== 1'b1 || core_rsp[0].user_tag !== 8'h50) begin
            n_fail++;
            $display("FAIL overflow_rsp: valid=%b tag=%h expected 1 50",
                     core_rsp[0].valid, core_rsp[0].user_tag);
        end
        step();
        mem_rsp.valid = 1'b0;
        issued = 1'b0;
        repeat (6) begin
            step();
            #1;
            if (mem_req.valid !== 1'b0) issued = 1'b1;
        end
        n_checks++;
        if (issued !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_dropped: extra issue=%b expected 0", issued);
        end
        n_checks++;
        if (protocol_err !== 1'b1 || core_rsp[0].ready !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: err=%b ready=%b expected 1 1",
                     protocol_err, core_rsp[0].ready);
        end
    endtask

    task automatic test_reset_in_wait();
        bit issued;
        step();
        core_req[1] = make_req(32'h6000, 32'h0, 1'b1, 8'h60);
        step();
        core_req[1].valid = 1'b0;
        step();
        #1;
        n_checks++;
        if (mem_req.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstwait_issue: got %b expected 1", mem_req.valid);
        end
        step();
        #1;
        n_checks++;
        if (mem_req.valid !== 1'b0 || core_rsp[1].ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_in_wait: mem_valid=%b ready=%b expected 0 0",
                     mem_req.valid, core_rsp[1].ready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (protocol_err !== 1'b0 || core_rsp[1].ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstwait_flushed: err=%b ready=%b expected 0 1",
                     protocol_err, core_rsp[1].ready);
        end
        step();
        step();
        mem_rsp.valid    = 1'b1;
        mem_rsp.addr     = 32'h6000;
        mem_rsp.data     = 32'hBAD0BAD0;
        mem_rsp.user_tag = 8'h60;
        #1;
        n_checks++;
        if (core_rsp[0].valid !== 1'b0 || core_rsp[1].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_stale: rsp0_valid=%b rsp1_valid=%b expected 0 0",
                     core_rsp[0].valid, core_rsp[1].valid);
        end
        step();
        mem_rsp.valid = 1'b0;
        issued = 1'b0;
        repeat (4) begin
            step();
            #1;
            if (mem_req.valid !== 1'b0) issued = 1'b1;
        end
        n_checks++;
        if (issued !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_idle: mem_req issued=%b expected 0", issued);
        end
    endtask

    // ------------------------------------------------------------- sequencing
    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one `memory_io` memory port between `NUM_PORTS` cache requesters (port 0 = data cache, port 1 = instruction cache in the default build). Each port's one-cycle request pulse is latched, a round-robin winner is selected, and exactly one transaction is kept outstanding at memory. The memory response is routed back to the owning port only. The block sits between the L1 caches and main memory.

## Interface
- `NUM_PORTS`, 2, number of requesters; legal range 2..4.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `core_req[NUM_PORTS]`  in  memory_io_req  per-port request; `valid` is a one-cycle pulse.
- `core_rsp[NUM_PORTS]`  out  memory_io_rsp  per-port response.
- `mem_req`  out  memory_io_req  request to memory.
- `mem_rsp`  in  memory_io_rsp  response from memory; `ready` accepts the request, `valid` delivers data.
- `protocol_err`  out  1  sticky; set when a request arrives at a port whose buffer is already full.

## Operation
- Per-port buffer holds one entry: `addr`, `data`, `do_read`, `do_write`, `user_tag`, `buf_valid[p]`.
  - `core_req[p].valid` loads the buffer on the next edge.
  - If `buf_valid[p]` is already 1 and the port is not being completed that cycle, the request is dropped, `protocol_err` is set, and the buffer is unchanged.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any `buf_valid` is set, the round-robin pick is stored in `owner`, `last_grant<=owner`, and the FSM goes to ISSUE. Otherwise it stays in IDLE.
  - ISSUE: `mem_req` equals `buf[owner]` with `valid=1`, `dummy=0`.
    - `mem_rsp.ready=0`: hold in ISSUE with the same payload.
    - `ready=1` and `mem_rsp.valid=0`: go to WAIT.
    - `ready=1` and `mem_rsp.valid=1`: complete the transaction (see below) and go to IDLE.
  - WAIT: `mem_req` equals `memory_io_no_req`. On `mem_rsp.valid`, complete the transaction and go to IDLE.
- Completing a transaction:
  - `core_rsp[owner]` gets `addr`, `data`, and `user_tag` from `mem_rsp`, with `valid=1`, combinationally in the same cycle.
  - `buf_valid[owner]` is cleared on the next edge.
  - If the owner presents a new request in the completion cycle, the load wins: the buffer ends valid with the new request and no error is flagged.
- Round-robin: the search starts at `last_grant+1` modulo `NUM_PORTS`. `last_grant` resets to `NUM_PORTS-1`, so port 0 wins the first tie.
- `core_rsp[p].ready = !buf_valid[p]`. `core_rsp[p].valid` is 0 for every non-owner, and for all ports in IDLE.
- Any `mem_rsp.valid` seen in IDLE (a stale response after reset) is dropped silently.
- `user_tag` is passed through unchanged. Routing uses `owner` only, never the tag.

## Timing
- Reset values:
  - `state=IDLE`, all `buf_valid=0`, `owner=0`, `last_grant=NUM_PORTS-1`, `protocol_err=0`.
  - `mem_req=memory_io_no_req`.
  - All `core_rsp`: `valid=0`, `ready=1`, data, addr and tag 0.
- Latency: request pulse in cycle N → buffered at the end of N → IDLE picks in N+1 → `mem_req.valid` in N+2 (memory ready, no contention).
- Response: zero-cycle pass-through from `mem_rsp.valid` to `core_rsp[owner].valid`. The earliest next grant is 1 cycle after completion (IDLE).
- At most one memory transaction is outstanding. The payload is stable for the whole of ISSUE.
- Reset mid-transaction: the buffers are flushed and the outstanding memory access is abandoned. Its late response is dropped in IDLE.

## Structure
- Add `arb_state_t` (IDLE/ISSUE/WAIT) and the `port_idx_t` width constant alongside `memory_io_req`/`memory_io_rsp` in the shared `memory_io.sv` header. `memory_io_no_req` is reused as-is.
- Sub-module `rr_pick`: combinational round-robin picker with a `NUM_PORTS`-bit request vector, a `last_grant` input, and `grant_idx` and `any` outputs. It is instantiated once.

## Test plan
- Single read: port 0 read pulse of addr 0x1000 at cycle 5, memory ready, `rsp.valid` with data 0xDEADBEEF at cycle 9 → `mem_req.valid` at cycle 7 with addr 0x1000, `do_read=4'b1111`; `core_rsp[0]` valid with 0xDEADBEEF at cycle 9; `core_rsp[1].valid=0` throughout.
- Contention and fairness: both ports pulse in the same cycle, repeated 4 times → grants alternate 0,1,0,1; every response lands only on its owner, with `user_tag` preserved.
- Back-to-back fill: port 1 issues its next request in the same cycle it receives a response (8-word fill, addr 0x2000..0x201C) → 8 memory reads in order, no dropped request, `protocol_err` stays 0.
- Memory backpressure: `mem_rsp.ready=0` for 3 cycles during ISSUE → `mem_req` held with an identical payload for 4 cycles, then WAIT.
- Overflow: port 0 pulses twice while its first request is outstanding → `protocol_err=1` and stays 1; the second request is not issued.
- Reset in WAIT, then `mem_rsp.valid` 2 cycles after reset → all `core_rsp.valid` stay 0; the FSM stays in IDLE.
